alu: RTL and testbench
======================

Name: alu

Overview:
8-bit arithmetic/logic unit for the processor datapath. It sits between the register file and the writeback mux. It computes a combinational result from two operands and a 3-bit operation select. It also keeps a small set of registered status flags that feed the branch logic.

Parameters:
WIDTH, 8, operand and result width in bits.
OP_W, 3, width of the operation select.

Ports:
CLK  input  1  system clock; status flags update on rising edge.
RESETn  input  1  asynchronous, active-low reset; clears registered flags.
data1  input  WIDTH  operand A (register file output 1).
data2  input  WIDTH  operand B (register file output 2 or immediate).
operation  input  OP_W  operation select (encoding below).
flag_en  input  1  when high, registered flags capture the current combinational flags on the rising edge.
result  output  WIDTH  combinational result.
zero  output  1  combinational: result == 0.
carry  output  1  combinational: carry-out of ADD; 0 for all other ops.
overflow  output  1  combinational: two's-complement overflow of ADD; 0 for other ops.
illegal_op  output  1  combinational: operation is in the range 4..7.
zero_q  output  1  registered zero flag.
carry_q  output  1  registered carry flag.
overflow_q  output  1  registered overflow flag.

Behaviour:
- Operation encoding:
  - 0 = FWD: result = data2 (move/load-immediate path; data1 ignored).
  - 1 = ADD: result = data1 + data2, modulo 2^WIDTH.
  - 2 = AND: result = data1 & data2, bitwise.
  - 3 = OR: result = data1 | data2, bitwise.
  - 4..7 reserved: result = 0, illegal_op = 1.
- result, zero, carry, overflow and illegal_op are purely combinational.
  - Zero-cycle latency; they settle within the same evaluation step as the inputs change.
  - No clock involvement and no #delays in RTL.
- ADD width rules:
  - Internal sum is WIDTH+1 bits; carry = sum[WIDTH].
  - overflow = (data1[MSB] == data2[MSB]) && (result[MSB] != data1[MSB]).
  - Wrap-around: 0xFF + 0x01 -> result 0x00, carry 1, zero 1, overflow 0.
  - 0x7F + 0x01 -> result 0x80, overflow 1, carry 0.
- zero is computed for every op, including FWD and reserved ops (reserved ops give zero = 1).
- Registered flags (zero_q, carry_q, overflow_q):
  - Asynchronous clear to 0 whenever RESETn is low, regardless of CLK.
  - On a rising CLK edge with RESETn high and flag_en = 1: load zero, carry, overflow.
  - With flag_en = 0: hold.
  - A reset asserted mid-operation clears the flags immediately. The combinational result is unaffected by reset.
  - Release of RESETn takes effect from the next rising edge.
- Reset values: zero_q = 0, carry_q = 0, overflow_q = 0. Combinational outputs have no reset value; they always follow the inputs.
- X/undriven operation: no requirement beyond synthesizable case with a default branch (the default branch implements the reserved-op behaviour).

Decomposition:
- Shared package alu_pkg:
  - Operation enum alu_op_e (OP_FWD = 3'd0, OP_ADD = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3).
  - Localparam ALU_WIDTH = 8.
  - flags struct {zero, carry, overflow}.
- One sub-module is natural: alu_flag_reg (async active-low reset, enable-gated 3-bit flag register).
- The combinational datapath stays in alu.

Test Plan:
- data1 = 3, data2 = 4, sweep op 0..3 -> result 00000100, 00000111, 00000000, 00000111; zero = 0, 0, 1, 0 respectively; illegal_op = 0.
- op = ADD, data1 = 0xFF, data2 = 0x01, flag_en = 1, one CLK edge -> result 0x00, carry = 1, zero = 1; after the edge zero_q = 1, carry_q = 1, overflow_q = 0.
- op = ADD, data1 = 0x7F, data2 = 0x01 -> result 0x80, overflow = 1, carry = 0; with flag_en = 0 across an edge, registered flags hold their previous values.
- op = 5, data1 = 0xAA, data2 = 0x55 -> result 0x00, illegal_op = 1, zero = 1, carry = 0.
- Registered flags set (carry_q = 1); drive RESETn low between clock edges -> all *_q go 0 immediately. result still tracks the inputs (FWD with data2 = 0x3C gives 0x3C).
- Random sweep of 1000 operand pairs over ops 0..3 -> result matches the reference model; carry/overflow match a 9-bit model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the datapath ALU: operation encoding, default width and the
// status-flag bundle that feeds the branch logic.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_FWD = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage : alu_pkg

// File: rtl/alu_flag_reg.sv
// Enable-gated status flag register with asynchronous active-low clear.
module alu_flag_reg
  import alu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  alu_flags_t flags_i,
  output alu_flags_t flags_o
);

  alu_flags_t flags_d;
  alu_flags_t flags_q;

  always_comb begin
    flags_d = flags_q;
    if (en_i) begin
      flags_d = flags_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;

endmodule : alu_flag_reg

// File: rtl/alu.sv
// Combinational 8-bit ALU (FWD/ADD/AND/OR) with registered status flags for
// the branch logic; reserved operations yield zero and raise illegal_op.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OP_W  = 3
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [OP_W-1:0]  operation,
  input  logic             flag_en,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal_op,
  output logic             zero_q,
  output logic             carry_q,
  output logic             overflow_q
);

  logic [WIDTH:0] sum;
  alu_flags_t     flags_now;
  alu_flags_t     flags_reg;

  // One extra bit on the adder so the carry-out falls out of the sum directly.
  assign sum = {1'b0, data1} + {1'b0, data2};

  always_comb begin
    result     = '0;
    carry      = 1'b0;
    overflow   = 1'b0;
    illegal_op = 1'b0;
    case (operation)
      OP_FWD: result = data2;
      OP_ADD: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                   (sum[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_AND: result = data1 & data2;
      OP_OR:  result = data1 | data2;
      default: illegal_op = 1'b1;
    endcase
  end

  assign zero = (result == '0);

  assign flags_now.zero     = zero;
  assign flags_now.carry    = carry;
  assign flags_now.overflow = overflow;

  alu_flag_reg u_flag_reg (
    .clk_i   (CLK),
    .rst_ni  (RESETn),
    .en_i    (flag_en),
    .flags_i (flags_now),
    .flags_o (flags_reg)
  );

  assign zero_q     = flags_reg.zero;
  assign carry_q    = flags_reg.carry;
  assign overflow_q = flags_reg.overflow;

endmodule : alu

// File: tb/tb_alu.sv
// Scoreboard bench for the ALU: expected outputs are queued when stimulus is
// driven and compared once the combinational outputs have settled.
module tb_alu;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
    logic       ill;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic [7:0] data1, data2;
  logic [2:0] operation;
  logic       flag_en;
  logic [7:0] result;
  logic       zero, carry, overflow, illegal_op;
  logic       zero_q, carry_q, overflow_q;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t last_exp;
  logic mz_q, mc_q, mv_q;

  alu dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .data1      (data1),
    .data2      (data2),
    .operation  (operation),
    .flag_en    (flag_en),
    .result     (result),
    .zero       (zero),
    .carry      (carry),
    .overflow   (overflow),
    .illegal_op (illegal_op),
    .zero_q     (zero_q),
    .carry_q    (carry_q),
    .overflow_q (overflow_q)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [8:0] s9;
    int sa, sb, ss;
    e.res = 8'h00; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0;
    s9 = {1'b0, a} + {1'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    ss = sa + sb;
    case (op)
      3'd0: e.res = b;
      3'd1: begin
        e.res = s9[7:0];
        e.c   = s9[8];
        e.v   = (ss > 127) || (ss < -128);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  task automatic apply(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    operation = op;
    data1     = a;
    data2     = b;
    sb_q.push_back(model(op, a, b));
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      last_exp = e;
      check({tag, "_result"},  result,     e.res);
      check({tag, "_zero"},    zero,       e.z);
      check({tag, "_carry"},   carry,      e.c);
      check({tag, "_ovf"},     overflow,   e.v);
      check({tag, "_illegal"}, illegal_op, e.ill);
    end
  endtask

  task automatic edge_and_check(input string tag);
    logic en_at_edge;
    @(posedge CLK);
    en_at_edge = flag_en;
    if (RESETn && en_at_edge) begin
      mz_q = last_exp.z;
      mc_q = last_exp.c;
      mv_q = last_exp.v;
    end
    #1;
    check({tag, "_zero_q"},  zero_q,     mz_q);
    check({tag, "_carry_q"}, carry_q,    mc_q);
    check({tag, "_ovf_q"},   overflow_q, mv_q);
    @(negedge CLK);
  endtask

  initial begin
    RESETn = 1'b0; flag_en = 1'b0;
    operation = 3'd0; data1 = 8'h00; data2 = 8'h00;
    mz_q = 1'b0; mc_q = 1'b0; mv_q = 1'b0;
    last_exp = model(3'd0, 8'h00, 8'h00);
    #1;
    check("rst_zero_q",  zero_q,     1'b0);
    check("rst_carry_q", carry_q,    1'b0);
    check("rst_ovf_q",   overflow_q, 1'b0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    // Directed: 3 and 4 across the legal ops
    for (int op = 0; op < 4; op++) begin
      apply($sformatf("sweep_op%0d", op), 3'(op), 8'd3, 8'd4);
    end
    check("sweep_add_res", result, 8'h07);

    // Wrap-around add loaded into the flags
    flag_en = 1'b1;
    apply("wrap", 3'd1, 8'hFF, 8'h01);
    edge_and_check("wrap");
    check("wrap_const_carry_q", carry_q, 1'b1);

    // Signed overflow with flags held
    flag_en = 1'b0;
    apply("ovf", 3'd1, 8'h7F, 8'h01);
    edge_and_check("hold");
    flag_en = 1'b1;
    edge_and_check("ovf_load");
    check("ovf_const_ovf_q", overflow_q, 1'b1);

    // Reserved op
    apply("rsv5", 3'd5, 8'hAA, 8'h55);
    apply("rsv7", 3'd7, 8'hFF, 8'hFF);

    // Async reset between edges, after carry_q is set
    apply("pre_rst", 3'd1, 8'hFF, 8'h01);
    edge_and_check("pre_rst");
    #2;
    RESETn = 1'b0;
    mz_q = 1'b0; mc_q = 1'b0; mv_q = 1'b0;
    #1;
    check("async_zero_q",  zero_q,     1'b0);
    check("async_carry_q", carry_q,    1'b0);
    check("async_ovf_q",   overflow_q, 1'b0);
    apply("rst_fwd", 3'd0, 8'h11, 8'h3C);
    edge_and_check("in_rst");
    RESETn = 1'b1;

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      flag_en = 1'($urandom_range(0, 1));
      apply("rand", 3'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      edge_and_check("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_alu
